// File: rtl/exe_stage_pkg.sv
// Shared execute-stage definitions: EXE_CMD encodings, status flag bit
// positions, bus widths, the EXE/MEM register payload and command helpers.
// Imported by the execute stage, its ALU and the control unit.
package exe_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned IMM_W  = 24;
  localparam int unsigned NZCV_W = 4;

  // Status bit positions within {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  // EXE/MEM pipeline register payload
  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] st_val;
  } exe_mem_t;

  // Commands that produce a result and update N/Z when S is set
  function automatic logic cmd_defined(input logic [CMD_W-1:0] cmd);
    return cmd inside {CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
                       CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR};
  endfunction

  // Commands that additionally update C/V
  function automatic logic cmd_arith(input logic [CMD_W-1:0] cmd);
    return cmd inside {CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC};
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports: a, b (operands), cmd (EXE_CMD), cin (current C flag);
//        result (32-bit result), nzcv (flags computed for this op; C/V are
//        only meaningful for arithmetic commands).
module alu
  import exe_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CMD_W-1:0]  cmd,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic [NZCV_W-1:0] nzcv
);

  logic [DATA_W:0] w_sum;
  logic            w_c;
  logic            w_v;
  logic            w_is_sub;

  // Subtraction is a + ~b + carry-in, so bit 32 is directly NOT borrow
  always_comb begin
    w_sum    = '0;
    w_is_sub = 1'b0;
    result   = '0;
    case (cmd)
      CMD_MOV: result = b;
      CMD_MVN: result = ~b;
      CMD_ADD: w_sum  = {1'b0, a} + {1'b0, b};
      CMD_ADC: w_sum  = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
      CMD_SUB: begin
        w_sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1'b1);
        w_is_sub = 1'b1;
      end
      CMD_SBC: begin
        w_sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(cin);
        w_is_sub = 1'b1;
      end
      CMD_AND: result = a & b;
      CMD_ORR: result = a | b;
      CMD_EOR: result = a ^ b;
      default: result = '0;
    endcase
    if (cmd_arith(cmd)) result = w_sum[DATA_W-1:0];
  end

  // Signed overflow: operands agree in sign (after negating b for subtract)
  // but the result sign differs
  always_comb begin
    w_c = cmd_arith(cmd) ? w_sum[DATA_W] : cin;
    w_v = 1'b0;
    if (cmd_arith(cmd)) begin
      if (w_is_sub)
        w_v = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      else
        w_v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    end
  end

  assign nzcv = {result[DATA_W-1], (result == '0), w_c, w_v};

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, status register, branch target and EXE/MEM register.
// Ports: clk, rst (sync, active-high), freeze (hold), flush (squash);
//        ID-side controls/operands in; registered EXE/MEM fields and status
//        out; branch_taken/branch_addr combinational.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [CMD_W-1:0]  exe_cmd,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [IMM_W-1:0]  imm24,
  output logic              valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [NZCV_W-1:0] status,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr
);

  exe_mem_t          r_ex;
  exe_mem_t          w_ex_load;
  logic [NZCV_W-1:0] r_status;
  logic [NZCV_W-1:0] w_status_nxt;
  logic              w_status_upd;
  logic [DATA_W-1:0] w_alu_res;
  logic [NZCV_W-1:0] w_alu_nzcv;

  alu u_alu (
    .a      (val_rn),
    .b      (val2),
    .cmd    (exe_cmd),
    .cin    (r_status[FLAG_C]),
    .result (w_alu_res),
    .nzcv   (w_alu_nzcv)
  );

  // Payload loaded on a normal edge; a bubble carries no enables
  always_comb begin
    w_ex_load          = '0;
    w_ex_load.valid    = in_valid;
    w_ex_load.wb_en    = in_valid & wb_en_in;
    w_ex_load.mem_r_en = in_valid & mem_r_en_in;
    w_ex_load.mem_w_en = in_valid & mem_w_en_in;
    w_ex_load.dest     = dest_in;
    w_ex_load.alu_res  = w_alu_res;
    w_ex_load.st_val   = val_rm;
  end

  // Logic ops and moves keep C/V; undefined commands touch nothing
  always_comb begin
    w_status_upd         = in_valid & s_in & cmd_defined(exe_cmd);
    w_status_nxt         = r_status;
    w_status_nxt[FLAG_N] = w_alu_nzcv[FLAG_N];
    w_status_nxt[FLAG_Z] = w_alu_nzcv[FLAG_Z];
    if (cmd_arith(exe_cmd)) begin
      w_status_nxt[FLAG_C] = w_alu_nzcv[FLAG_C];
      w_status_nxt[FLAG_V] = w_alu_nzcv[FLAG_V];
    end
  end

  // EXE/MEM register and status; priority rst > flush > freeze > load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex     <= '0;
      r_status <= '0;
    end else if (flush) begin
      r_ex.valid    <= 1'b0;
      r_ex.wb_en    <= 1'b0;
      r_ex.mem_r_en <= 1'b0;
      r_ex.mem_w_en <= 1'b0;
    end else if (!freeze) begin
      r_ex <= w_ex_load;
      if (w_status_upd) r_status <= w_status_nxt;
    end
  end

  assign valid    = r_ex.valid;
  assign wb_en    = r_ex.wb_en;
  assign mem_r_en = r_ex.mem_r_en;
  assign mem_w_en = r_ex.mem_w_en;
  assign dest     = r_ex.dest;
  assign alu_res  = r_ex.alu_res;
  assign st_val   = r_ex.st_val;
  assign status   = r_status;

  // Branch resolves in this cycle; word offset sign-extended to 32 bits
  assign branch_taken = in_valid & b_in & ~freeze;
  assign branch_addr  = pc_in + {{(DATA_W-IMM_W-2){imm24[IMM_W-1]}}, imm24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        b_in, s_in;
  logic [3:0]  exe_cmd, dest_in;
  logic [31:0] val_rn, val2, val_rm, pc_in;
  logic [23:0] imm24;
  logic        valid, wb_en, mem_r_en, mem_w_en, branch_taken;
  logic [3:0]  dest, status;
  logic [31:0] alu_res, st_val, branch_addr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic        valid, wb, mr, mw;
    logic [3:0]  dest;
    logic [31:0] res, st;
    logic [3:0]  status;
    bit          dchk;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd(exe_cmd), .dest_in(dest_in),
    .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .pc_in(pc_in), .imm24(imm24),
    .valid(valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .dest(dest), .alu_res(alu_res), .st_val(st_val), .status(status),
    .branch_taken(branch_taken), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference ALU written from signed/unsigned arithmetic on 64-bit values
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, b,
                                  input logic cin, output logic [31:0] r,
                                  output logic c, v, output bit def, arith);
    longint sa, sbv, sr;
    longint unsigned ua, ub;
    int ci;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    r = '0; c = cin; v = 1'b0; def = 1; arith = 0; ci = 0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        ci = (cmd == 4'd3 && cin) ? 1 : 0;
        r = a + b + 32'(ci);
        c = (ua + ub + 64'(ci)) > 64'hFFFF_FFFF;
        sr = sa + sbv + longint'(ci);
        v = (sr > SMAX) || (sr < SMIN);
        arith = 1;
      end
      4'd4, 4'd5: begin
        ci = (cmd == 4'd5 && !cin) ? 1 : 0;
        r = a - b - 32'(ci);
        c = ua >= (ub + 64'(ci));
        sr = sa - sbv - longint'(ci);
        v = (sr > SMAX) || (sr < SMIN);
        arith = 1;
      end
      default: def = 0;
    endcase
  endfunction

  // Predict next state, push it, clock, then pop and compare
  task automatic cycle();
    exp_t nxt, e;
    logic [31:0] r, ba;
    logic c, v;
    bit def, arith;
    #1;
    ba = pc_in + 32'(longint'($signed(imm24)) * 4);
    chk("branch_taken", 32'(branch_taken), 32'(in_valid & b_in & !freeze));
    chk("branch_addr", branch_addr, ba);
    ref_alu(exe_cmd, val_rn, val2, m.status[1], r, c, v, def, arith);
    nxt = m;
    if (rst) begin
      nxt = '{valid:0, wb:0, mr:0, mw:0, dest:0, res:0, st:0, status:0, dchk:1};
    end else if (flush) begin
      nxt.valid = 0; nxt.wb = 0; nxt.mr = 0; nxt.mw = 0; nxt.dchk = 0;
    end else if (!freeze) begin
      nxt.valid = in_valid;
      nxt.wb = in_valid & wb_en_in;
      nxt.mr = in_valid & mem_r_en_in;
      nxt.mw = in_valid & mem_w_en_in;
      nxt.dest = dest_in; nxt.res = r; nxt.st = val_rm;
      nxt.dchk = in_valid;
      if (in_valid && s_in && def) begin
        nxt.status[3] = r[31];
        nxt.status[2] = (r == 32'd0);
        if (arith) begin nxt.status[1] = c; nxt.status[0] = v; end
      end
    end
    m = nxt;
    sb.push_back(nxt);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("valid", 32'(valid), 32'(e.valid));
    chk("wb_en", 32'(wb_en), 32'(e.wb));
    chk("mem_r_en", 32'(mem_r_en), 32'(e.mr));
    chk("mem_w_en", 32'(mem_w_en), 32'(e.mw));
    chk("status", 32'(status), 32'(e.status));
    if (e.dchk) begin
      chk("dest", 32'(dest), 32'(e.dest));
      chk("alu_res", alu_res, e.res);
      chk("st_val", st_val, e.st);
    end
  endtask

  task automatic drive(input logic iv, s, b, input logic [3:0] cmd,
                       input logic [31:0] rn, v2);
    in_valid = iv; s_in = s; b_in = b; exe_cmd = cmd; val_rn = rn; val2 = v2;
    wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
    dest_in = 4'($urandom); val_rm = $urandom; pc_in = $urandom; imm24 = 24'($urandom);
  endtask

  initial begin
    m = '{valid:0, wb:0, mr:0, mw:0, dest:0, res:0, st:0, status:0, dchk:0};
    rst = 1; freeze = 0; flush = 0;
    drive(1, 1, 0, 4'd2, 32'd1, 32'd2);
    cycle(); cycle();
    chk("reset_status", 32'(status), 32'h0);
    rst = 0;

    // ADD overflow into sign bit
    drive(1, 1, 0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    cycle();
    chk("add_res", alu_res, 32'h8000_0000);
    chk("add_nzcv", 32'(status), 32'h9);

    // SUB equal operands, then SBC with C=1
    drive(1, 1, 0, 4'b0100, 32'd5, 32'd5);
    cycle();
    chk("sub_res", alu_res, 32'h0);
    chk("sub_nzcv", 32'(status), 32'h6);
    drive(1, 1, 0, 4'b0101, 32'd5, 32'd1);
    cycle();
    chk("sbc_res", alu_res, 32'd4);

    // Branch resolves in the same cycle
    drive(1, 0, 1, 4'b0001, 32'd0, 32'h1234);
    pc_in = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    chk("br_taken_direct", 32'(branch_taken), 32'd1);
    chk("br_addr_direct", branch_addr, 32'h0F8);
    cycle();

    // Logic ops, moves, carry-in ops, undefined command with S set
    drive(1, 1, 0, 4'd6, 32'hF0F0_0000, 32'h8F00_0000); cycle();
    drive(1, 1, 0, 4'd7, 32'h0, 32'h0);                 cycle();
    drive(1, 1, 0, 4'd8, 32'hAAAA_5555, 32'h5555_AAAA); cycle();
    drive(1, 1, 0, 4'd9, 32'h0, 32'h0);                 cycle();
    drive(1, 1, 0, 4'd2, 32'hFFFF_FFFF, 32'd1);         cycle();
    drive(1, 1, 0, 4'd3, 32'd10, 32'd20);               cycle();
    drive(1, 1, 0, 4'd5, 32'h8000_0000, 32'd1);         cycle();
    drive(1, 1, 0, 4'hF, 32'h1, 32'h1);                 cycle();
    chk("undef_res", alu_res, 32'h0);
    drive(1, 0, 0, 4'd1, 32'h0, 32'h0);                 cycle();

    // Freeze for three cycles with changing inputs, then release
    drive(1, 1, 0, 4'd4, 32'd3, 32'd7); cycle();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 4'(2 + i), $urandom, $urandom);
      cycle();
    end
    freeze = 0;
    drive(1, 1, 0, 4'd2, 32'h8000_0000, 32'h8000_0000); cycle();

    // Flush wins over freeze
    flush = 1; freeze = 1;
    drive(1, 1, 0, 4'd1, 32'h0, 32'h0); wb_en_in = 1;
    cycle();
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_wb", 32'(wb_en), 32'd0);
    flush = 0; freeze = 0;

    // Bubble
    drive(0, 1, 1, 4'd2, 32'h1, 32'h1); cycle();

    // Reset while a valid instruction holds nonzero status
    drive(1, 1, 0, 4'd2, 32'h8000_0000, 32'h8000_0000); cycle();
    rst = 1;
    drive(1, 1, 1, 4'd2, 32'h1, 32'h1); cycle();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_status", 32'(status), 32'h0);
    rst = 0;

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      rst    = ($urandom_range(0, 19) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
